mem_port_arbiter: RTL

- Shares one single-ported memory bus between NCORES execute stages, one in-flight transaction at a time.
- Each core presents its execute-stage memory op (valid/addr/wdata/write) and is held by a per-core stall until the op completes.
- Grants are round-robin. Read data returns on a shared bus, qualified by a per-core one-cycle valid.

---
 rtl/mem_port_arbiter.sv | 220 ++++++++++++++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
//
// Shares one single-ported memory bus between NCORES execute stages. Only one
// transaction is in flight at a time. Grants rotate round-robin: the core that
// just completed gets the lowest priority in the next arbitration.
//
// Optional feature (compile-time macro ARB_TIMEOUT_EN):
//   defined   - a watchdog aborts a transaction that has spent TIMEOUT_CYCLES
//               cycles in ISSUE/WAIT without completing. The core then gets a
//               completion pulse with rsp_data = 32'hFFFFFFFF, and err pulses
//               in the same cycle.
//   undefined - no watchdog. err is tied low, and a hung memory keeps the
//               granted core stalled.
//
// Ports:
//   clk, rst    clock; synchronous active-high reset
//   req_valid   [NCORES]     core i has a memory op pending
//   req_addr    [32*NCORES]  address of core i in bits [32i+31:32i]
//   req_wdata   [32*NCORES]  store data, packed like req_addr
//   req_write   [NCORES]     1 = store, 0 = load
//   stall       [NCORES]     hold core i (combinational from req_valid)
//   rsp_valid   [NCORES]     one-cycle completion pulse for core i
//   rsp_data    [32]         load data, valid while any rsp_valid bit is high
//   mem_req/mem_addr/mem_wdata/mem_write   request to memory
//   mem_ready   memory accepts the request this cycle
//   mem_rvalid/mem_rdata     read data return
//   err         watchdog timeout pulse (0 when ARB_TIMEOUT_EN is undefined)
// -----------------------------------------------------------------------------
module mem_port_arbiter #(
  parameter int NCORES         = 4,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NCORES-1:0]    req_valid,
  input  logic [32*NCORES-1:0] req_addr,
  input  logic [32*NCORES-1:0] req_wdata,
  input  logic [NCORES-1:0]    req_write,
  output logic [NCORES-1:0]    stall,
  output logic [NCORES-1:0]    rsp_valid,
  output logic [31:0]          rsp_data,
  output logic                 mem_req,
  output logic [31:0]          mem_addr,
  output logic [31:0]          mem_wdata,
  output logic                 mem_write,
  input  logic                 mem_ready,
  input  logic                 mem_rvalid,
  input  logic [31:0]          mem_rdata,
  output logic                 err
);

  localparam int IW  = (NCORES > 1) ? $clog2(NCORES) : 1;
  localparam int IW1 = IW + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t state_reg, state_next;

  logic [IW-1:0] grant_reg;
  logic [IW-1:0] rr_ptr_reg;
  logic [IW-1:0] pick;
  logic [IW-1:0] grant_inc;
  logic [31:0]   mem_addr_reg;
  logic [31:0]   mem_wdata_reg;
  logic [31:0]   rsp_data_reg;
  logic          mem_write_reg;
  logic          any_req;
  logic          timeout_fire;

  logic [31:0]       core_addr  [NCORES];
  logic [31:0]       core_wdata [NCORES];
  logic [IW-1:0]     scan_idx   [NCORES];
  logic [NCORES-1:0] scan_req;

  // Per-core slices. scan_idx[k] is the core visited k-th when scanning up
  // from rr_ptr with wrap. Because rr_ptr and k are both below NCORES, a
  // single conditional subtract is enough for the wrap.
  generate
    for (genvar gi = 0; gi < NCORES; gi++) begin : g_core
      logic [IW1-1:0] sum;
      assign core_addr[gi]  = req_addr[32*gi +: 32];
      assign core_wdata[gi] = req_wdata[32*gi +: 32];
      assign sum            = {1'b0, rr_ptr_reg} + IW1'(gi);
      assign scan_idx[gi]   = (sum >= IW1'(NCORES)) ? IW'(sum - IW1'(NCORES))
                                                    : sum[IW-1:0];
      assign scan_req[gi]   = req_valid[scan_idx[gi]];
      // A core is released only in the DONE cycle of its own transaction. A
      // core with no request never stalls.
      assign stall[gi] = req_valid[gi] &
                         ~((state_reg == DONE) && (grant_reg == IW'(gi)));
    end
  endgenerate

  // The scan runs from the far end down so that the closest requester wins.
  always_comb begin
    pick = scan_idx[0];
    for (int k = NCORES - 1; k >= 0; k--) begin
      if (scan_req[k]) pick = scan_idx[k];
    end
  end

  assign any_req   = |req_valid;
  assign grant_inc = (grant_reg == IW'(NCORES - 1)) ? '0 : grant_reg + 1'b1;

`ifdef ARB_TIMEOUT_EN
  logic [31:0] tmo_cnt_reg;
  logic        err_reg;
  logic        tmo_limit;

  // The counter holds the number of cycles already spent in ISSUE/WAIT. The
  // limit therefore trips during the TIMEOUT_CYCLES-th such cycle, unless the
  // memory completes in that same cycle.
  assign tmo_limit    = (tmo_cnt_reg >= 32'(TIMEOUT_CYCLES - 1));
  assign timeout_fire = ((state_reg == ISSUE) && !mem_ready  && tmo_limit) ||
                        ((state_reg == WAIT)  && !mem_rvalid && tmo_limit);

  always_ff @(posedge clk) begin
    if (rst) begin
      tmo_cnt_reg <= '0;
      err_reg     <= 1'b0;
    end else begin
      // ISSUE is only entered from IDLE, so clearing in IDLE clears on entry.
      if (state_reg == IDLE) begin
        tmo_cnt_reg <= '0;
      end else if ((state_reg == ISSUE) || (state_reg == WAIT)) begin
        tmo_cnt_reg <= tmo_cnt_reg + 32'd1;
      end
      // A timeout always moves to DONE, so this pulse lines up with DONE.
      err_reg <= timeout_fire;
    end
  end

  assign err = err_reg;
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
  assign timeout_fire       = 1'b0;
  assign err                = 1'b0;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (any_req) state_next = ISSUE;
      end
      ISSUE: begin
        if (mem_ready)         state_next = mem_write_reg ? DONE : WAIT;
        else if (timeout_fire) state_next = DONE;
      end
      WAIT: begin
        if (mem_rvalid || timeout_fire) state_next = DONE;
      end
      DONE: begin
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Datapath registers: the request captured at grant, the response data,
  // and the round-robin pointer.
  always_ff @(posedge clk) begin
    if (rst) begin
      grant_reg     <= '0;
      rr_ptr_reg    <= '0;
      mem_addr_reg  <= '0;
      mem_wdata_reg <= '0;
      mem_write_reg <= 1'b0;
      rsp_data_reg  <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (any_req) begin
            grant_reg     <= pick;
            mem_addr_reg  <= core_addr[pick];
            mem_wdata_reg <= core_wdata[pick];
            mem_write_reg <= req_write[pick];
          end
        end
        ISSUE: begin
          if (timeout_fire) rsp_data_reg <= '1;
        end
        WAIT: begin
          if (mem_rvalid)        rsp_data_reg <= mem_rdata;
          else if (timeout_fire) rsp_data_reg <= '1;
        end
        DONE: begin
          rr_ptr_reg <= grant_inc;
        end
        default: ;
      endcase
    end
  end

  // Outputs
  always_comb begin
    mem_req   = (state_reg == ISSUE);
    mem_addr  = mem_addr_reg;
    mem_wdata = mem_wdata_reg;
    mem_write = mem_write_reg;
    rsp_data  = rsp_data_reg;
    rsp_valid = '0;
    if (state_reg == DONE) rsp_valid[grant_reg] = 1'b1;
  end

endmodule
